fb_scanout: RTL and testbench
=============================

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, clocks per line (front porch 16, sync 96, back porch 48).
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame (front porch 10, sync 2, back porch 33).
REQ-005 SHALL have parameter FB_WIDTH, default 160, frame-buffer pixels per row (scale factor 4 in both axes).
REQ-006 SHALL have parameter FB_DEPTH, default 19200, frame-buffer words (160x120).
REQ-007 clk  input  1  pixel clock (25.175 MHz nominal), one pixel per cycle; single clock domain.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 enable  input  1  scan-out enable; sampled only at frame start.
REQ-010 mem_address  output  15  frame-buffer read address, registered.
REQ-011 mem_chipselect  output  1  frame-buffer access strobe, registered.
REQ-012 mem_readdata  input  8  frame-buffer data, RGB332, valid one clock after mem_address is presented (memory registers address, unregistered q).
REQ-013 vga_r / vga_g / vga_b  output  8 each  pixel colour.
REQ-014 vga_hs / vga_vs  output  1 each  sync, active-low.
REQ-015 vga_blank_n  output  1  high during active video.
REQ-016 vga_sync_n  output  1  constant 0.
REQ-017 frame_start  output  1  one-clock pulse aligned with first visible pixel of each frame.

Function
REQ-018 SHALL keep h_cnt 0..H_TOTAL-1, incrementing every clk, wrapping to 0; v_cnt 0..V_TOTAL-1, incrementing on h_cnt wrap, wrapping to 0.
REQ-019 SHALL define active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); hs_raw low for h_cnt 656..751; vs_raw low for v_cnt 490..491.
REQ-020 SHALL generate the address with no multiplier: row_base (15 bits) += FB_WIDTH when v_cnt[1:0]==3 at h_cnt wrap during active lines, cleared to 0 at v_cnt wrap; mem_address = row_base + h_cnt[9:2].
REQ-021 SHALL assert mem_chipselect only for active cycles with frame-enable set; mem_address SHALL hold its last value otherwise.
REQ-022 SHALL never present mem_address >= FB_DEPTH; last read of frame is address 19199.
REQ-023 SHALL delay active, hs_raw, vs_raw and frame-start by exactly 3 clocks through a pipeline so that outputs match the pixel at (h_cnt,v_cnt) three clocks earlier: stage1 address register, stage2 memory q, stage3 output register.
REQ-024 SHALL expand RGB332 in stage3: r = {d[7:5],d[7:5],d[7:6]}, g = {d[4:2],d[4:2],d[4:3]}, b = {d[1:0],d[1:0],d[1:0],d[1:0]}.
REQ-025 SHALL drive vga_r/g/b = 0 whenever delayed active is 0 or frame-enable is 0.
REQ-026 SHALL latch frame-enable from enable when h_cnt==0 and v_cnt==0; mid-frame changes of enable SHALL take effect only at next frame.
REQ-027 SHALL pulse frame_start for exactly one clock at output stage when pixel (0,0) is driven, regardless of enable.
REQ-028 Sync timing SHALL continue with enable=0 (monitor stays locked).

Reset
REQ-029 On reset_n low, asynchronously: h_cnt, v_cnt, row_base, mem_address = 0; mem_chipselect = 0; frame-enable = 0; all pipeline stages cleared; vga_r/g/b = 0; vga_hs = vga_vs = 1; vga_blank_n = 0; frame_start = 0.
REQ-030 After reset_n rises, counting SHALL start at (0,0) on the first clk edge; first frame is blank (frame-enable 0) unless enable was high at that first (0,0) sample.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no partial-state recovery required.

Verification
REQ-032 Reset release, enable=1 held -> frame_start first high 3 clocks after counter (0,0); vga_hs period 800 clocks, low 96; vga_vs period 420000 clocks, low 1600.
REQ-033 Memory model with word k = k[7:0]: line 0 pixels 0-3 show word 0, pixels 636-639 word 159; lines 4-7 start at word 160; last visible pixel shows word 19199.
REQ-034 mem_readdata=8'hE0 everywhere -> vga_r=8'hFF, vga_g=0, vga_b=0 in active; all zero while vga_blank_n=0.
REQ-035 enable dropped at v_cnt=200 -> current frame completes with pixels; next frame rgb=0 and mem_chipselect never high, sync unchanged.
REQ-036 reset_n pulsed low at v_cnt=300 -> outputs go to reset values same cycle; after release timing restarts from (0,0).
REQ-037 Full-frame address monitor -> mem_address never >= 19200, each address read exactly 16 times per frame.

Source files
------------

// File: rtl/fb_scanout.sv
// Frame-buffer to VGA scan-out: 4x-scaled RGB332 buffer, 3-stage pixel pipeline.
// Timing counters, multiplier-free address walk, sync and blanking generation.
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int FB_WIDTH = 160,
    parameter int FB_DEPTH = 19200,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [14:0] mem_address,
    output logic        mem_chipselect,
    input  logic [7:0]  mem_readdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start
);

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] FB_W   = 15'(FB_WIDTH);
    localparam logic [14:0] FB_D   = 15'(FB_DEPTH);

    logic [9:0]  h_cnt, v_cnt;
    logic [14:0] row_base;
    logic        frame_en;

    logic        h_wrap, v_wrap, at_origin, fe_now;
    logic        active, hs_raw, vs_raw, rd;
    logic [14:0] addr_nxt;

    logic s1_act, s1_hs, s1_vs, s1_fs;
    logic s2_act, s2_hs, s2_vs, s2_fs, s2_cs;

    assign vga_sync_n = 1'b0;

    always_comb begin
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        // Enable sampled at the origin applies to that very pixel
        fe_now    = at_origin ? enable : frame_en;
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_raw    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        addr_nxt  = row_base + {7'd0, h_cnt[9:2]};
        rd        = active && fe_now && (addr_nxt < FB_D);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
            frame_en <= 1'b0;
        end else begin
            frame_en <= fe_now;
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
                if (v_wrap)
                    row_base <= '0;
                else if ((v_cnt < V_ACT) && (v_cnt[1:0] == 2'd3))
                    row_base <= row_base + FB_W;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Stage 1 address, stage 2 memory q, stage 3 output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            s1_act <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_fs  <= 1'b0;
            s2_act <= 1'b0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_fs  <= 1'b0;
            s2_cs  <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            mem_chipselect <= rd;
            if (rd)
                mem_address <= addr_nxt;
            s1_act <= active;
            s1_hs  <= hs_raw;
            s1_vs  <= vs_raw;
            s1_fs  <= at_origin;
            s2_act <= s1_act;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_fs  <= s1_fs;
            s2_cs  <= mem_chipselect;
            vga_hs <= s2_hs;
            vga_vs <= s2_vs;
            vga_blank_n <= s2_act;
            frame_start <= s2_fs;
            if (s2_cs && s2_act) begin
                vga_r <= {mem_readdata[7:5], mem_readdata[7:5], mem_readdata[7:6]};
                vga_g <= {mem_readdata[4:2], mem_readdata[4:2], mem_readdata[4:3]};
                vga_b <= {4{mem_readdata[1:0]}};
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a shrunken raster (24x16 clocks per frame).
// Independent pixel model feeds an expected-output queue compared 3 clocks later.
module tb_fb_scanout;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HT  = 24;
    localparam int VA  = 12;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VT  = 16;
    localparam int FBW = 4;
    localparam int FBD = 12;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic [7:0]  mem_readdata;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

    fb_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .FB_WIDTH(FBW), .FB_DEPTH(FBD),
        .H_FP(HFP), .H_SYNC(HS), .V_FP(VFP), .V_SYNC(VS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .mem_address(mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_readdata(mem_readdata),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic       blank_n;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    px_t         sbq[$];
    int          pat;
    int          mh, mv;
    logic        mfe;
    logic [14:0] last_addr;
    int          rd_cnt[FBD];
    int          hs_low, vs_low;
    int          n_chk, n_pass, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] word(int k);
        case (pat)
            0:       return k[7:0];
            1:       return 8'hE0;
            default: return 8'(k * 37 + 5);
        endcase
    endfunction

    // Registered-address memory: q follows the address sampled one edge earlier
    always @(posedge clk) mem_readdata <= word(int'(mem_address));

    function automatic logic [23:0] expand(logic [7:0] d);
        logic [7:0] r, g, b;
        r = 8'((int'(d[7:5]) * 255 + 3) / 7);
        g = 8'((int'(d[4:2]) * 255 + 3) / 7);
        b = 8'(int'(d[1:0]) * 85);
        return {r, g, b};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d)",
                   tag, obs, want, mh, mv);
        end
    endtask

    task automatic tick();
        px_t  e;
        logic act, rd;
        int   a;
        if (mh == 0 && mv == 0) mfe = enable;
        act = (mh < HA) && (mv < VA);
        rd  = act && mfe;
        a   = (mv / 4) * FBW + mh / 4;
        e.blank_n = act;
        e.hs = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
        e.vs = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
        e.fs = (mh == 0) && (mv == 0);
        if (rd) {e.r, e.g, e.b} = expand(word(a));
        else    {e.r, e.g, e.b} = 24'd0;
        sbq.push_back(e);
        @(posedge clk);
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
        @(negedge clk);
        chk("cs", 32'(mem_chipselect), 32'(rd));
        if (rd) last_addr = 15'(a);
        chk("addr", 32'(mem_address), 32'(last_addr));
        if (mem_chipselect) begin
            chk("addr_range", 32'(mem_address < 15'(FBD)), 32'd1);
            if (mem_address < 15'(FBD)) rd_cnt[int'(mem_address)]++;
        end
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (sbq.size() == 3) begin
            e = sbq.pop_front();
            chk("blank_n", 32'(vga_blank_n), 32'(e.blank_n));
            chk("hs", 32'(vga_hs), 32'(e.hs));
            chk("vs", 32'(vga_vs), 32'(e.vs));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("r", 32'(vga_r), 32'(e.r));
            chk("g", 32'(vga_g), 32'(e.g));
            chk("b", 32'(vga_b), 32'(e.b));
            chk("sync_n", 32'(vga_sync_n), 32'd0);
        end
    endtask

    task automatic run_frame();
        repeat (HT * VT) tick();
    endtask

    task automatic clear_counts();
        foreach (rd_cnt[k]) rd_cnt[k] = 0;
        hs_low = 0;
        vs_low = 0;
    endtask

    task automatic check_counts(int each);
        foreach (rd_cnt[k]) chk("reads", 32'(rd_cnt[k]), 32'(each));
        chk("hs_low", 32'(hs_low), 32'(VT * HS));
        chk("vs_low", 32'(vs_low), 32'(VS * HT));
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
        chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_sync_n"}, 32'(vga_sync_n), 32'd0);
    endtask

    task automatic model_reset();
        sbq.delete();
        mh = 0;
        mv = 0;
        mfe = 1'b0;
        last_addr = '0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        pat = 0;
        reset_n = 1'b0;
        enable = 1'b1;
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        chk_reset("por");
        reset_n = 1'b1;

        clear_counts();
        run_frame();
        check_counts(16);

        pat = 1;
        clear_counts();
        run_frame();
        check_counts(16);

        pat = 2;
        clear_counts();
        repeat (6 * HT) tick();
        enable = 1'b0;
        repeat ((VT - 6) * HT) tick();
        check_counts(16);

        clear_counts();
        repeat (2 * HT) tick();
        enable = 1'b1;
        repeat ((VT - 2) * HT) tick();
        check_counts(0);

        repeat (6 * HT + 5) tick();
        #2 reset_n = 1'b0;
        #1 chk_reset("mid");
        model_reset();
        @(negedge clk);
        chk_reset("mid_hold");
        reset_n = 1'b1;

        pat = 0;
        clear_counts();
        run_frame();
        check_counts(16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
